// File: rtl/module_switches_ctrl_pkg.sv
// rtl/module_switches_ctrl_pkg.sv - shared constants and types for the switch bank controller
// Register word addresses (addr_i[3:2]), edge-select encoding and CTRL bit positions.
package pkg_switches;

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  localparam int CTRL_EDGE_LSB   = 0;
  localparam int CTRL_EDGE_MSB   = 1;
  localparam int CTRL_BYPASS_BIT = 2;
  localparam int CTRL_W          = 3;

endpackage

// File: rtl/module_switches_ctrl_debounce.sv
// rtl/module_switches_ctrl_debounce.sv - one-bit synchroniser plus tick-sampled debouncer
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   in_i          : raw asynchronous pad bit
//   tick_i        : one-cycle sample strobe
//   bypass_i      : when high, db_o follows the synchronised bit directly
//   db_o          : debounced level
module module_debounce
  import pkg_switches::*;
#(
  parameter int DB_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  input  logic tick_i,
  input  logic bypass_i,
  output logic db_o
);

  logic                s1_q, s2_q;
  logic [DB_DEPTH-1:0] hist_q, hist_d;
  logic                db_q, db_d;

  always_comb begin
    hist_d = hist_q;
    db_d   = db_q;
    if (tick_i) begin
      hist_d = {hist_q[DB_DEPTH-2:0], s2_q};
    end
    // Acceptance looks at the post-shift history so the level changes on the
    // same edge that completes the run of equal samples.
    if (bypass_i) begin
      db_d = s2_q;
    end else if (tick_i && (&hist_d)) begin
      db_d = 1'b1;
    end else if (tick_i && !(|hist_d)) begin
      db_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= '0;
      db_q   <= 1'b0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      hist_q <= hist_d;
      db_q   <= db_d;
    end
  end

  // In bypass the flop also tracks s2_q, so leaving bypass produces no step.
  assign db_o = bypass_i ? s2_q : db_q;

endmodule

// File: rtl/module_switches_ctrl.sv
// rtl/module_switches_ctrl.sv - memory-mapped debounced switch bank with sticky edge events and irq
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   sw_bt_i[N_IN]      : raw switch/button pads
//   rd_i, we_i         : bus read / write strobes
//   addr_i[3:0]        : byte address, bits [3:2] decoded
//   wdata_i, rdata_o   : bus write data / registered read data
//   irq_o              : OR of (EVENT & IRQ_EN)
module module_switches_ctrl
  import pkg_switches::*;
#(
  parameter int N_IN     = 20,
  parameter int TICK_DIV = 50000,
  parameter int DB_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_IN-1:0] sw_bt_i,
  input  logic            rd_i,
  input  logic            we_i,
  input  logic [3:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            irq_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick;
  logic [N_IN-1:0]   db;
  logic [N_IN-1:0]   prev_q;
  logic [N_IN-1:0]   event_q, event_d;
  logic [N_IN-1:0]   irq_en_q, irq_en_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_IN-1:0]   set_v, clr_v;
  logic              bypass;
  edge_sel_e         edge_sel;
  logic [1:0]        reg_sel;
  logic              unused_ok;

  assign reg_sel   = addr_i[3:2];
  assign bypass    = ctrl_q[CTRL_BYPASS_BIT];
  assign unused_ok = ^{addr_i[1:0], wdata_i};

  // Free-running sample tick; bus activity never touches it.
  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  for (genvar g = 0; g < N_IN; g++) begin : g_db
    module_debounce #(
      .DB_DEPTH(DB_DEPTH)
    ) u_db (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .in_i    (sw_bt_i[g]),
      .tick_i  (tick),
      .bypass_i(bypass),
      .db_o    (db[g])
    );
  end

  always_comb begin
    edge_sel = edge_sel_e'(ctrl_q[CTRL_EDGE_MSB:CTRL_EDGE_LSB]);
    set_v    = '0;
    case (edge_sel)
      EDGE_RISE: set_v = db & ~prev_q;
      EDGE_FALL: set_v = ~db & prev_q;
      EDGE_BOTH: set_v = db ^ prev_q;
      default:   set_v = '0;
    endcase
  end

  always_comb begin
    clr_v    = '0;
    irq_en_d = irq_en_q;
    ctrl_d   = ctrl_q;
    if (we_i) begin
      case (reg_sel)
        ADDR_EVENT:  clr_v    = wdata_i[N_IN-1:0];
        ADDR_IRQ_EN: irq_en_d = wdata_i[N_IN-1:0];
        ADDR_CTRL:   ctrl_d   = wdata_i[CTRL_W-1:0];
        default:     ;
      endcase
    end
    // Clearing first, then OR-ing the new edges, makes a same-cycle set win.
    event_d = (event_q & ~clr_v) | set_v;
  end

  // Reads sample the current flops, so a simultaneous write is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_i) begin
      case (reg_sel)
        ADDR_STATE:  rdata_d = 32'(db);
        ADDR_EVENT:  rdata_d = 32'(event_q);
        ADDR_IRQ_EN: rdata_d = 32'(irq_en_q);
        default:     rdata_d = 32'(ctrl_q);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      prev_q   <= '0;
      event_q  <= '0;
      irq_en_q <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      prev_q   <= db;
      event_q  <= event_d;
      irq_en_q <= irq_en_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = |(event_q & irq_en_q);

endmodule
